inst_loader: RTL and testbench

Instruction-memory loader: the write side of the instruction memory that the single-cycle CPU fetches from. It receives a framed byte stream over a valid/ready handshake and assembles it into 32-bit little-endian words. Each word is written to instruction memory at consecutive word-aligned byte addresses. The CPU is held in reset until a complete, checksum-verified program has been loaded.

---
 rtl/inst_loader_if.sv | 24 ++
 rtl/inst_loader.sv | 141 ++++++++++++++
 tb/tb_inst_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Stream and instruction-memory write bundle for inst_loader.
//   in_valid / in_data / in_ready : byte stream, transfer = in_valid & in_ready
//   mem_we / mem_addr / mem_wdata : instruction-memory write port (word writes)
// master = stream source / memory sink side, slave = the loader itself.
interface inst_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction-memory loader. Receives a framed byte stream
// (LEN_LO, LEN_HI, 4N payload bytes, XOR checksum), assembles little-endian
// 32-bit words, writes them to consecutive word addresses and releases the
// CPU reset only after the checksum of a complete frame matches.
// Ports:
//   CLK        clock, all state on rising edge
//   RST        asynchronous active-low reset
//   start      one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus        stream input and memory write port (inst_loader_if.slave)
//   cpu_rst_n  low holds the CPU in reset, high after a successful load
//   busy       high while a frame is being received
//   error      high after a rejected length or checksum
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN0   | expecting low byte of word count
// LEN1   | expecting high byte of word count, range check
// DATA   | receiving payload bytes, one word write per 4 bytes
// CHECK  | expecting checksum byte
// DONE   | load verified, CPU released
// ERROR  | bad length or checksum, CPU held in reset
module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    inst_loader_if.slave       bus,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam int unsigned WORDS_MAX = 32'd1 << (ADDR_W - 2);

    logic [2:0]        state;
    logic [7:0]        len_lo;
    logic [15:0]       words_left;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              xfer;
    logic [15:0]       len_n;
    logic              len_bad;

    assign busy         = (state == S_LEN0) || (state == S_LEN1) ||
                          (state == S_DATA) || (state == S_CHECK);
    assign error        = (state == S_ERROR);
    assign cpu_rst_n    = (state == S_DONE);
    assign bus.in_ready = busy;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign xfer    = bus.in_valid & busy;
    assign len_n   = {bus.in_data, len_lo};
    assign len_bad = (len_n == 16'd0) || (32'(len_n) > WORDS_MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            len_lo      <= '0;
            words_left  <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            csum        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) state <= S_LEN0;
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo <= bus.in_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state <= S_ERROR;
                        end else begin
                            state      <= S_DATA;
                            words_left <= len_n;
                            word_idx   <= '0;
                            byte_idx   <= '0;
                            csum       <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.in_data;
                            2'd1: word_buf[15:8]  <= bus.in_data;
                            2'd2: word_buf[23:16] <= bus.in_data;
                            default: begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= {bus.in_data, word_buf};
                                mem_addr_q  <= {word_idx, 2'b00};
                                // word_idx wraps to 0 after a full-capacity
                                // load; the frame ends there so it is harmless
                                word_idx    <= word_idx + 1'b1;
                                words_left  <= words_left - 16'd1;
                                if (words_left == 16'd1) state <= S_CHECK;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        state <= (bus.in_data == csum) ? S_DONE : S_ERROR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic CLK;
    logic RST;
    logic start;
    logic cpu_rst_n;
    logic busy;
    logic error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] payload[$];

    inst_loader_if #(.ADDR_W(10)) bus ();

    inst_loader #(.ADDR_W(10)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .error     (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every cycle in which the write strobe is high is recorded as one write.
    always @(negedge CLK) begin
        if (bus.mem_we === 1'b1)
            wr_q.push_back('{32'(bus.mem_addr), bus.mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one byte which the next posedge accepts.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        bit gap;
        gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge CLK);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge CLK);
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n,     0);
        check({tag, "_busy"},      busy,          0);
        check({tag, "_error"},     error,         0);
    endtask

    // Full load of the frame described by n and the payload queue; the
    // reference is derived from the frame rules alone.
    task automatic run_frame(input string tag, input int n, input bit bad_chk,
                             input int gap_mode, input bit start_mid);
        logic [15:0] nn;
        logic [7:0]  x;
        bit          ok_len;
        bit          ok;
        int          exp_writes;
        int          cmp_n;
        nn     = n[15:0];
        ok_len = (n >= 1) && (n <= 256);
        ok     = ok_len && !bad_chk;
        x      = 8'h00;
        if (ok_len) foreach (payload[i]) x ^= payload[i];
        wr_q.delete();

        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        check({tag, "_start_ready"},   bus.in_ready, 1);
        check({tag, "_start_cpu_rst"}, cpu_rst_n,    0);
        check({tag, "_start_error"},   error,        0);
        @(negedge CLK);
        start = 1'b0;

        send_byte(nn[7:0], gap_mode);
        send_byte(nn[15:8], gap_mode);
        if (ok_len) begin
            for (int i = 0; i < 4 * n; i++) begin
                start = start_mid && (i == 2);
                send_byte(payload[i], gap_mode);
                start = 1'b0;
            end
            send_byte(bad_chk ? (x ^ 8'h01) : x, gap_mode);
        end
        bus.in_valid = 1'b0;

        check({tag, "_error"},     error,        !ok);
        check({tag, "_cpu_rst_n"}, cpu_rst_n,    ok);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_in_ready"},  bus.in_ready, 0);

        exp_writes = ok_len ? n : 0;
        check({tag, "_nwrites"}, wr_q.size(), exp_writes);
        cmp_n = (wr_q.size() < exp_writes) ? wr_q.size() : exp_writes;
        for (int i = 0; i < cmp_n; i++) begin
            check({tag, "_addr"}, wr_q[i].addr, 32'(4 * i));
            check({tag, "_data"}, wr_q[i].data,
                  {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]});
        end
    endtask

    task automatic load_program;
        payload.delete();
        payload.push_back(8'h93); payload.push_back(8'h00);
        payload.push_back(8'h50); payload.push_back(8'h00);
        payload.push_back(8'h13); payload.push_back(8'h01);
        payload.push_back(8'h10); payload.push_back(8'h00);
    endtask

    initial begin
        RST          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Good load with known words
        load_program();
        run_frame("good", 2, 1'b0, 0, 1'b0);
        if (wr_q.size() == 2) begin
            check("good_w0", wr_q[0].data, 32'h00500093);
            check("good_w1", wr_q[1].data, 32'h00100113);
            check("good_a1", wr_q[1].addr, 32'h4);
        end else begin
            check("good_count", wr_q.size(), 2);
        end

        // start in DONE: drops cpu_rst_n and raises in_ready on the next edge
        run_frame("restart_done", 2, 1'b0, 0, 1'b0);

        // Bad checksum (C0), writes still happen; next start clears error
        run_frame("badchk", 2, 1'b1, 0, 1'b0);
        run_frame("after_err", 2, 1'b0, 0, 1'b0);

        // Length bounds
        run_frame("len0", 0, 1'b0, 0, 1'b0);
        run_frame("len257", 257, 1'b0, 0, 1'b0);
        fill_random(256);
        run_frame("len256", 256, 1'b0, 0, 1'b0);
        if (wr_q.size() == 256) check("len256_last_addr", wr_q[255].addr, 32'h3FC);

        // Gapped stream, in_valid toggling every cycle
        load_program();
        run_frame("gapped", 2, 1'b0, 1, 1'b0);

        // start pulse during DATA is ignored
        load_program();
        run_frame("start_mid", 2, 1'b0, 0, 1'b1);

        // Reset after the 6th payload byte
        wr_q.delete();
        load_program();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(payload[i], 0);
        RST = 1'b0;
        #1;
        check_reset_values("midrst");
        check("midrst_nwrites", wr_q.size(), 1);
        if (wr_q.size() >= 1) check("midrst_addr", wr_q[0].addr, 0);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        RST          = 1'b1;
        @(negedge CLK);
        run_frame("post_rst", 2, 1'b0, 0, 1'b0);

        // Randomized frames
        for (int t = 0; t < 12; t++) begin
            int n;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = $urandom_range(257, 65535);
            else               n = $urandom_range(1, 6);
            fill_random((n >= 1 && n <= 256) ? n : 0);
            run_frame("rand", n, ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
